// File: rtl/miso_oversample_capture_pkg.sv
// miso_oversample_capture_pkg: widths and state encoding shared with the phase selector
package miso_oversample_capture_pkg;
    localparam int MISO4X_W = 134;
    localparam int MISO_W = 33;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/miso_sync.sv
// miso_sync: STAGES-deep single-bit synchronizer with synchronous reset
module miso_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk)
        ff <= rst ? '0 : {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/miso_oversample_capture.sv
// miso_oversample_capture: syncs MISO and captures one frame of 4x samples into MISO4x
module miso_oversample_capture
    import miso_oversample_capture_pkg::*;
#(
    parameter int N_SAMPLES   = MISO4X_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 MISO_pin,
    input  logic                 frame_start,
    input  logic                 sample_en,
    output logic [N_SAMPLES-1:0] MISO4x,
    output logic                 frame_done,
    output logic                 capturing,
    output logic [7:0]           sample_count
);
    localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);
    logic                 miso_s;
    state_t               state;
    logic [7:0]           count;
    logic [N_SAMPLES-1:0] shadow, shadow_nx;
    miso_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(dataclk),
        .rst(reset),
        .d  (MISO_pin),
        .q  (miso_s)
    );
    // shadow with the current sample merged, so the final bit lands in MISO4x on completion
    always_comb begin
        shadow_nx = shadow;
        shadow_nx[count] = miso_s;
    end
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            shadow     <= '0;
            MISO4x     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                state <= CAPTURE;
                count <= {7'd0, sample_en};
                if (sample_en) shadow[0] <= miso_s;
            end else if (state == CAPTURE && sample_en) begin
                shadow <= shadow_nx;
                count  <= count + 8'd1;
                if (count == LAST) begin
                    state      <= DONE;
                    MISO4x     <= shadow_nx;
                    frame_done <= 1'b1;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
    assign capturing    = (state == CAPTURE);
    assign sample_count = count;
endmodule

// File: tb/tb_miso_oversample_capture.sv
// tb_miso_oversample_capture: directed and random frames checked against a sample-list model
module tb_miso_oversample_capture;
    localparam int N  = 134;
    localparam int SS = 2;
    logic           dataclk = 1'b0;
    logic           reset, MISO_pin, frame_start, sample_en;
    logic [N-1:0]   MISO4x;
    logic           frame_done, capturing;
    logic [7:0]     sample_count;
    int             n_vec = 0, n_bad = 0, n_done = 0;
    bit             sq[$];
    bit             smp[$];
    bit             active = 0, e_done = 0;
    logic [N-1:0]   e_m4x = '0;
    logic [N-1:0]   pat;
    miso_oversample_capture #(.N_SAMPLES(N), .SYNC_STAGES(SS)) dut (
        .dataclk     (dataclk),
        .reset       (reset),
        .MISO_pin    (MISO_pin),
        .frame_start (frame_start),
        .sample_en   (sample_en),
        .MISO4x      (MISO4x),
        .frame_done  (frame_done),
        .capturing   (capturing),
        .sample_count(sample_count)
    );
    always #5 dataclk = ~dataclk;
    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // one clock: apply inputs, advance the model over the edge, then compare
    task automatic cyc(input bit r, input bit p, input bit fs, input bit se);
        bit ms;
        reset = r; MISO_pin = p; frame_start = fs; sample_en = se;
        @(posedge dataclk);
        ms = sq.pop_front();
        sq.push_back(p);
        e_done = 0;
        if (r) begin
            sq = {};
            repeat (SS) sq.push_back(1'b0);
            smp = {};
            active = 0;
            e_m4x = '0;
        end else if (fs) begin
            active = 1;
            smp = {};
            if (se) smp.push_back(ms);
        end else if (active && se) begin
            smp.push_back(ms);
            if (smp.size() == N) begin
                for (int i = 0; i < N; i++) e_m4x[i] = smp[i];
                e_done = 1;
                active = 0;
            end
        end
        #1;
        chk("frame_done", N'(frame_done), N'(e_done));
        chk("capturing", N'(capturing), N'(active));
        chk("sample_count", N'(sample_count), N'(smp.size()));
        chk("MISO4x", MISO4x, e_m4x);
        if (frame_done) n_done++;
    endtask
    initial begin
        repeat (SS) sq.push_back(1'b0);
        repeat (3) cyc(1, 1, 0, 0);
        chk("reset_miso4x", MISO4x, '0);
        for (int j = 0; j < 136; j++) cyc(0, (j % 3) == 0, j == 2, j >= 2);
        for (int i = 0; i < N; i++) pat[i] = (i % 3) == 0;
        chk("pattern_word", MISO4x, pat);
        chk("pattern_count", N'(sample_count), N'(134));
        repeat (3) cyc(0, 1, 0, 0);
        n_done = 0;
        for (int j = 0; j < 536; j++) cyc(0, 1, j == 0, (j % 4) == 0);
        repeat (2) cyc(0, 1, 0, 1);
        chk("gap_done_pulses", N'(n_done), N'(1));
        chk("gap_all_ones", MISO4x, '1);
        repeat (3) cyc(0, 0, 0, 0);
        n_done = 0;
        for (int j = 0; j < 50; j++) cyc(0, 0, j == 0, 1);
        for (int j = 0; j < 133; j++) cyc(0, 0, j == 0, 1);
        chk("abort_held", MISO4x, '1);
        chk("abort_no_done", N'(n_done), N'(0));
        cyc(0, 0, 0, 1);
        chk("abort_zero", MISO4x, '0);
        chk("abort_one_done", N'(n_done), N'(1));
        for (int j = 0; j < 80; j++) cyc(0, 1'($urandom), j == 0, 1);
        cyc(1, 1'($urandom), 0, 1);
        chk("rst_mid_capturing", N'(capturing), N'(0));
        chk("rst_mid_count", N'(sample_count), N'(0));
        n_done = 0;
        for (int j = 0; j < 134; j++) cyc(0, 1'($urandom), j == 0, 1);
        for (int j = 0; j < 134; j++) cyc(0, 1'($urandom), j == 0, 1);
        cyc(0, 0, 0, 0);
        chk("b2b_done_pulses", N'(n_done), N'(2));
        for (int j = 0; j < 2000; j++)
            cyc(($urandom % 500) == 0, 1'($urandom), ($urandom % 150) == 0, ($urandom % 4) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
